// File: rtl/ins_fetch_queue.sv
// Fetch front end: issues one-outstanding icache requests, predicts JAL/B-type
// targets with a 2-bit BHT, and buffers fetched words in a FIFO for dispatch.
module ins_fetch_queue #(
    parameter int          IQ_DEPTH  = 16,
    parameter int          BHT_IDX_W = 8,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback_signal,
    input  logic [31:0] rollback_pc,
    output logic        fetch_req,
    output logic [31:0] fetch_pc,
    input  logic        icache_valid,
    input  logic [31:0] icache_instr,
    input  logic        is_full,
    output logic        valid_2dsp,
    output logic [31:0] pc_2dsp,
    output logic [31:0] instr_2dsp,
    output logic        if_jump_2dsp,
    input  logic        br_commit_valid,
    input  logic [31:0] br_commit_pc,
    input  logic        br_commit_taken
);
    localparam int PTR_W    = $clog2(IQ_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int BHT_SIZE = 1 << BHT_IDX_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(IQ_DEPTH);
    localparam logic [6:0]       OP_JAL     = 7'b1101111;
    localparam logic [6:0]       OP_BRANCH  = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        fetch_req_reg, fetch_req_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;

    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      q_pc    [IQ_DEPTH];
    logic [31:0]      q_instr [IQ_DEPTH];
    logic             q_jump  [IQ_DEPTH];

    logic [1:0]           bht_reg [BHT_SIZE];
    logic [BHT_IDX_W-1:0] pred_idx, commit_idx;
    logic                 unused_commit_bits;

    logic [31:0] j_imm, b_imm, pred_next_pc;
    logic        pred_taken;
    logic        do_push, do_pop;

    // Prediction is against the PC of the single outstanding request.
    assign pred_idx   = pc_reg[BHT_IDX_W+1:2];
    assign commit_idx = br_commit_pc[BHT_IDX_W+1:2];
    assign unused_commit_bits = ^{br_commit_pc[31:BHT_IDX_W+2], br_commit_pc[1:0]};

    assign j_imm = {{11{icache_instr[31]}}, icache_instr[31], icache_instr[19:12],
                    icache_instr[20], icache_instr[30:21], 1'b0};
    assign b_imm = {{19{icache_instr[31]}}, icache_instr[31], icache_instr[7],
                    icache_instr[30:25], icache_instr[11:8], 1'b0};

    always_comb begin
        pred_taken   = 1'b0;
        pred_next_pc = pc_reg + 32'd4;
        case (icache_instr[6:0])
            OP_JAL: begin
                pred_taken   = 1'b1;
                pred_next_pc = pc_reg + j_imm;
            end
            OP_BRANCH: begin
                pred_taken = bht_reg[pred_idx][1];
                if (pred_taken)
                    pred_next_pc = pc_reg + b_imm;
            end
            default: ;
        endcase
    end

    assign do_pop = rdy && !rollback_signal && (count_reg != '0) && !is_full;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        fetch_req_next = fetch_req_reg;
        fetch_pc_next  = fetch_pc_reg;
        do_push        = 1'b0;
        if (!rdy) begin
            state_next = state_reg;
        end else if (rollback_signal) begin
            // A request still in flight must be drained before issuing again.
            pc_next        = rollback_pc;
            fetch_req_next = 1'b0;
            case (state_reg)
                S_WAIT, S_FLUSH: state_next = icache_valid ? S_IDLE : S_FLUSH;
                default:         state_next = S_IDLE;
            endcase
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (count_reg < DEPTH_CNT) begin
                        fetch_req_next = 1'b1;
                        fetch_pc_next  = pc_reg;
                        state_next     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (icache_valid) begin
                        do_push        = 1'b1;
                        pc_next        = pred_next_pc;
                        fetch_req_next = 1'b0;
                        state_next     = S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (icache_valid)
                        state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            pc_reg        <= RESET_PC;
            fetch_req_reg <= 1'b0;
            fetch_pc_reg  <= 32'h0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            fetch_req_reg <= fetch_req_next;
            fetch_pc_reg  <= fetch_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (rdy) begin
            if (rollback_signal) begin
                head_reg  <= tail_reg;
                count_reg <= '0;
            end else begin
                if (do_pop)
                    head_reg <= head_reg + 1'b1;
                if (do_push)
                    tail_reg <= tail_reg + 1'b1;
                case ({do_push, do_pop})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            q_pc[tail_reg]    <= pc_reg;
            q_instr[tail_reg] <= icache_instr;
            q_jump[tail_reg]  <= pred_taken;
        end
    end

    // Same-cycle prediction reads see the value before this update lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++)
                bht_reg[i] <= 2'b01;
        end else if (rdy && br_commit_valid) begin
            if (br_commit_taken) begin
                if (bht_reg[commit_idx] != 2'b11)
                    bht_reg[commit_idx] <= bht_reg[commit_idx] + 2'd1;
            end else if (bht_reg[commit_idx] != 2'b00) begin
                bht_reg[commit_idx] <= bht_reg[commit_idx] - 2'd1;
            end
        end
    end

    assign fetch_req    = fetch_req_reg;
    assign fetch_pc     = fetch_pc_reg;
    assign valid_2dsp   = (count_reg != '0);
    assign pc_2dsp      = q_pc[head_reg];
    assign instr_2dsp   = q_instr[head_reg];
    assign if_jump_2dsp = q_jump[head_reg];

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Randomized bench for ins_fetch_queue: a queue-based reference model of the
// fetch/predict/dispatch behaviour is compared against the DUT every cycle.
module tb_ins_fetch_queue;
    localparam int DEPTH = 16;
    localparam int NCYC  = 2500;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback_signal, icache_valid, is_full;
    logic        br_commit_valid, br_commit_taken;
    logic [31:0] rollback_pc, icache_instr, br_commit_pc;
    logic        fetch_req, valid_2dsp, if_jump_2dsp;
    logic [31:0] fetch_pc, pc_2dsp, instr_2dsp;

    always #5 clk = ~clk;

    ins_fetch_queue #(.IQ_DEPTH(DEPTH), .BHT_IDX_W(8), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rollback_signal(rollback_signal), .rollback_pc(rollback_pc),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .icache_valid(icache_valid), .icache_instr(icache_instr),
        .is_full(is_full),
        .valid_2dsp(valid_2dsp), .pc_2dsp(pc_2dsp), .instr_2dsp(instr_2dsp),
        .if_jump_2dsp(if_jump_2dsp),
        .br_commit_valid(br_commit_valid), .br_commit_pc(br_commit_pc),
        .br_commit_taken(br_commit_taken)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: state 0=idle 1=waiting 2=flushing; queue as an SV queue.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        jump;
    } ent_t;

    ent_t        mq[$];
    int          m_state;
    logic [31:0] m_pc, m_fpc;
    logic        m_req;
    int          m_bht[256];

    // icache model: the word it returns carries its intended category and offset.
    logic        ic_armed;
    int          ic_delay, ic_cat, ic_off;
    logic [31:0] ic_word;

    function automatic logic [31:0] enc_jal(input int off);
        logic [20:0] i;
        i = 21'(off);
        return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_beq(input int off);
        logic [12:0] i;
        i = 13'(off);
        return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_state  = 0;
        m_pc     = 32'h0;
        m_fpc    = 32'h0;
        m_req    = 1'b0;
        ic_armed = 1'b0;
        for (int i = 0; i < 256; i++) m_bht[i] = 1;
    endtask

    task automatic gen_word(input bit nop_only);
        int r;
        r      = nop_only ? 0 : int'($urandom_range(0, 99));
        ic_off = (int'($urandom_range(0, 255)) - 128) * 2;
        if (r < 35) begin
            ic_cat = 0; ic_word = 32'h00000013;
        end else if (r < 50) begin
            ic_cat = 1; ic_word = enc_jal(ic_off);
        end else if (r < 85) begin
            ic_cat = 2; ic_word = enc_beq(ic_off);
        end else if (r < 90) begin
            ic_cat = 3; ic_word = {$urandom_range(0, 4095) , 5'd1, 3'b000, 5'd0, 7'b1100111};
        end else begin
            ic_cat = 4; ic_word = {$urandom_range(0, 33554431), 7'b0110011};
        end
    endtask

    task automatic model_step(input logic rdy_i, input logic rb_i, input logic [31:0] rb_pc_i,
                              input logic iv_i, input logic full_i, input logic cv_i,
                              input logic [31:0] cpc_i, input logic ct_i);
        logic        taken;
        logic [31:0] nxt;
        int          sz, ci;
        ent_t        e;
        if (!rdy_i) return;
        taken = 1'b0;
        nxt   = m_pc + 32'd4;
        if (ic_cat == 1) begin
            taken = 1'b1; nxt = m_pc + 32'(ic_off);
        end else if (ic_cat == 2 && m_bht[int'(m_pc[9:2])] >= 2) begin
            taken = 1'b1; nxt = m_pc + 32'(ic_off);
        end
        sz = mq.size();
        if (rb_i) begin
            mq.delete();
            m_pc  = rb_pc_i;
            m_req = 1'b0;
            if (m_state != 0) m_state = iv_i ? 0 : 2;
        end else begin
            if (sz != 0 && !full_i) begin
                e = mq.pop_front();
                $display("dispatch pc=%h instr=%h jump=%0d", e.pc, e.instr, e.jump);
            end
            case (m_state)
                0: if (sz < DEPTH) begin
                    m_req = 1'b1; m_fpc = m_pc; m_state = 1;
                end
                1: if (iv_i) begin
                    e.pc = m_pc; e.instr = ic_word; e.jump = taken;
                    mq.push_back(e);
                    m_pc = nxt; m_req = 1'b0; m_state = 0;
                end
                default: if (iv_i) m_state = 0;
            endcase
        end
        if (cv_i) begin
            ci = int'(cpc_i[9:2]);
            if (ct_i && m_bht[ci] < 3) m_bht[ci]++;
            else if (!ct_i && m_bht[ci] > 0) m_bht[ci]--;
        end
    endtask

    initial begin
        bit nop_only;
        int r;
        rst = 1'b1; rdy = 1'b1; rollback_signal = 1'b0; rollback_pc = 32'h0;
        icache_valid = 1'b0; icache_instr = 32'h0; is_full = 1'b0;
        br_commit_valid = 1'b0; br_commit_pc = 32'h0; br_commit_taken = 1'b0;
        model_reset();
        ic_cat = 0; ic_off = 0; ic_word = 32'h13; ic_delay = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_fetch_req", 32'(fetch_req), 32'h0);
        check("reset_fetch_pc", fetch_pc, 32'h0);
        check("reset_valid", 32'(valid_2dsp), 32'h0);
        rst = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            check("fetch_req", 32'(fetch_req), 32'(m_req));
            if (m_req) check("fetch_pc", fetch_pc, m_fpc);
            check("valid_2dsp", 32'(valid_2dsp), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("pc_2dsp", pc_2dsp, mq[0].pc);
                check("instr_2dsp", instr_2dsp, mq[0].instr);
                check("if_jump_2dsp", 32'(if_jump_2dsp), 32'(mq[0].jump));
            end

            nop_only = (cyc < 150);
            if (m_state == 0) ic_armed = 1'b0;
            if (m_state != 0 && !ic_armed) begin
                ic_armed = 1'b1;
                ic_delay = int'($urandom_range(0, 3));
                gen_word(nop_only);
            end
            icache_valid = ic_armed && (ic_delay == 0);
            icache_instr = icache_valid ? ic_word : $urandom;

            if (cyc < 150) begin
                rdy = 1'b1; rollback_signal = 1'b0; br_commit_valid = 1'b0;
                is_full = (cyc >= 40 && cyc < 110);
            end else begin
                rdy             = ($urandom_range(0, 99) >= 10);
                is_full         = ($urandom_range(0, 99) < 30);
                rollback_signal = ($urandom_range(0, 99) < 3);
                r = int'($urandom_range(0, 2));
                rollback_pc     = (r == 0) ? 32'h20 : (r == 1) ? 32'h100 : ($urandom & 32'hffff_fffc);
                br_commit_valid = ($urandom_range(0, 99) < 30);
                br_commit_pc    = $urandom_range(0, 1) ? m_pc : ($urandom & 32'hffff_fffc);
                br_commit_taken = $urandom_range(0, 1) != 0;
            end

            if (cyc == 1200) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
                model_step(rdy, rollback_signal, rollback_pc, icache_valid, is_full,
                           br_commit_valid, br_commit_pc, br_commit_taken);
            end
            if (ic_delay > 0) ic_delay--;
            @(posedge clk);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ins_fetch_queue.md
Name: ins_fetch_queue

Overview:
- Front-end stage directly upstream of the dispatcher.
- Generates fetch PCs and requests instruction words from the icache over a one-outstanding handshake.
- Predicts JAL and B-type control flow with a 2-bit-counter BHT, which is trained by ROB branch commits.
- Buffers fetched words in a FIFO whose head is presented combinationally to the dispatcher.

Parameters:
IQ_DEPTH, 16, instruction-queue entries (power of 2, >=2)
BHT_IDX_W, 8, BHT index width; index = pc[BHT_IDX_W+1:2]
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low = freeze all state
rollback_signal  in  1  misprediction flush from ROB
rollback_pc  in  32  correct PC after flush
fetch_req  out  1  icache request valid, registered
fetch_pc  out  32  icache request address, stable while fetch_req high
icache_valid  in  1  icache response strobe, 1 cycle
icache_instr  in  32  instruction word, valid with icache_valid
is_full  in  1  downstream (ROB/RS/LSB) cannot accept this cycle
valid_2dsp  out  1  queue head valid
pc_2dsp  out  32  head PC
instr_2dsp  out  32  head instruction
if_jump_2dsp  out  1  head predicted taken
br_commit_valid  in  1  ROB commits a B-type instruction
br_commit_pc  in  32  its PC
br_commit_taken  in  1  its actual outcome

Behaviour:
- Priority per cycle: rst > ~rdy (hold everything; no pop, no push, no BHT update) > rollback_signal > normal.
- Reset state:
  - pc = RESET_PC; state IDLE; queue empty (head = tail = count = 0).
  - fetch_req = 0, fetch_pc = 0, valid_2dsp = 0.
  - Every BHT entry = 2'b01 (weakly not-taken).
- Dispatcher outputs:
  - valid_2dsp = (count != 0).
  - pc/instr/if_jump are the head entry; they are don't-care when empty.
  - Pop on clk edge when valid_2dsp && ~is_full && rdy && ~rollback_signal. Dispatcher samples the same edge, so there are zero extra cycles of latency from queue to dispatcher.
- FSM states: IDLE, WAIT, FLUSH.
  - IDLE: if count < IQ_DEPTH → fetch_req <= 1, fetch_pc <= pc, go WAIT. Otherwise stay; fetch_req = 0.
  - WAIT: fetch_req held high, fetch_pc held. On icache_valid:
    - push {pc, icache_instr, pred_taken};
    - pc <= next_pc;
    - fetch_req <= 0;
    - go IDLE.
  - Minimum issue interval: one word every 2 cycles.
  - FLUSH: fetch_req = 0. Waits for the stale in-flight response; on icache_valid, discard it and go IDLE.
- Prediction, combinational on icache_instr, with p = pc:
  - opcode 1101111 (JAL): taken = 1; next_pc = p + sext(J-imm).
  - opcode 1100011 (B-type): taken = BHT[p idx][1]; next_pc = taken ? p + sext(B-imm) : p + 4.
  - All others, including JALR: taken = 0; next_pc = p + 4. JALR is resolved by rollback.
  - Arithmetic is 32-bit modulo 2^32.
- Rollback:
  - Queue emptied (count = 0, head = tail). pc <= rollback_pc.
  - From WAIT without icache_valid that cycle → FLUSH.
  - From WAIT with icache_valid the same cycle → response dropped, go IDLE.
  - From IDLE → IDLE.
  - From FLUSH → stay FLUSH, pc updated. If icache_valid arrives the same cycle, it is the stale response: go IDLE.
  - No pop occurs in a rollback cycle.
- BHT update, when br_commit_valid && rdy, independent of rollback:
  - Saturating ±1 at index br_commit_pc[BHT_IDX_W+1:2]; +1 if taken, −1 otherwise; saturates at 0 and 3.
  - If the same-cycle prediction reads the same index, it uses the pre-update value.
- Simultaneous push and pop: count unchanged; both pointers advance modulo IQ_DEPTH.
- Full (count == IQ_DEPTH): no new request issued. A request already in WAIT cannot exist at full, since issue requires count < IQ_DEPTH and only one request is outstanding.
- rst mid-WAIT: return to IDLE directly, with no FLUSH. The icache is reset by the same rst.

Test Plan:
- Reset, then icache returns 32'h00000013 each request, is_full = 0: fetch_pc sequence 0, 4, 8, one request per 2 cycles; dispatcher sees pc 0, 4, 8 with if_jump = 0.
- Word at pc 0 = JAL x0, +16 (32'h0100006f): if_jump_2dsp = 1 for pc 0; next fetch_pc = 32'h10.
- BEQ +8 at pc 32'h20, after two commits of br_commit_pc = 32'h20 taken: counter 01 → 11; next fetch of 32'h20 predicts taken; fetch_pc = 32'h28. Two not-taken commits then give pc+4.
- Hold is_full = 1 with NOPs: count reaches 16, fetch_req stays 0; release → one pop per cycle, pc order preserved across pointer wrap.
- Rollback to 32'h100 while in WAIT: queue empties, valid_2dsp = 0 next cycle. The next icache_valid (instr 32'hdeadbeef) is discarded. The next fetch_pc = 32'h100.
- rdy = 0 for 3 cycles mid-WAIT, with icache_valid pulsed and is_full = 0: no push, no pop, no pc change; resumes identically when rdy = 1.
